// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and default operand width for the shift-add multiplier
package mult_pkg;
  localparam int MULT_N = 4;
  typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, DONE} state_t;
endpackage

// File: rtl/mult_control.sv
// mult_control: shift-add multiplier sequencer driving the ACC load/ad/sh strobes
module mult_control
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic m,
  output logic load,
  output logic ad,
  output logic sh,
  output logic busy,
  output logic done
);
  localparam int KW = $clog2(N);
  state_t state;
  logic [KW-1:0] k;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
    end else
      case (state)
        IDLE:  state <= start ? LOAD : IDLE;
        LOAD: begin
          k     <= '0;
          state <= ADD;
        end
        ADD:   state <= SHIFT;
        SHIFT: begin
          state <= (k == KW'(N - 1)) ? DONE : ADD;
          k     <= (k == KW'(N - 1)) ? k : k + 1'b1;
        end
        DONE:  state <= start ? DONE : IDLE;
        default: state <= IDLE;
      endcase
  assign load = state == LOAD;
  assign ad   = (state == ADD) && m;
  assign sh   = state == SHIFT;
  assign busy = (state == LOAD) || (state == ADD) || (state == SHIFT);
  assign done = state == DONE;
endmodule

// File: tb/tb_mult_control.sv
// tb_mult_control: controller + ACC + 5-bit adder model, checked against a*b and strobe timing
module tb_mult_control;
  import mult_pkg::*;
  localparam int N = MULT_N;
  logic clk = 0, rst_n = 0, start = 1;
  logic load, ad, sh, busy, done;
  logic [3:0] mcand, mplier;
  logic [8:0] acc = '0;
  int vectors = 0, miscompares = 0;
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [8:0] prod;
  } vec_t;
  vec_t tbl[5];
  mult_control #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m(acc[0]),
    .load(load), .ad(ad), .sh(sh), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk)
    if (load) acc <= {5'b0, mplier};
    else if (ad) acc[8:4] <= {1'b0, acc[7:4]} + {1'b0, mcand};
    else if (sh) acc <= acc >> 1;
  wire [4:0] outs = {load, ad, sh, busy, done};
  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [4:0] exp_out(input int c, input logic [3:0] b);
    logic l, a, s, bz, d;
    l  = c == 1;
    a  = c >= 2 && c <= 2 * N && c % 2 == 0 && b[(c - 2) / 2];
    s  = c >= 3 && c <= 2 * N + 1 && c % 2 == 1;
    bz = c >= 1 && c <= 2 * N + 1;
    d  = c == 2 * N + 2;
    return {l, a, s, bz, d};
  endfunction
  task automatic run(input logic [3:0] a, input logic [3:0] b, input bit hold, input logic [8:0] prod);
    mcand  = a;
    mplier = b;
    start  = 1;
    for (int c = 1; c <= 2 * N + 2; c++) begin
      @(negedge clk);
      if (!hold) start = 0;
      check($sformatf("strobes %0dx%0d c%0d", a, b, c), {4'b0, outs}, {4'b0, exp_out(c, b)});
    end
    check($sformatf("product %0dx%0d", a, b), acc, prod);
    if (!hold) begin
      @(negedge clk);
      check("idle after done", {4'b0, outs}, 9'd0);
    end
  endtask
  initial begin
    tbl[0] = '{4'd13, 4'd11, 9'd143};
    tbl[1] = '{4'd15, 4'd0, 9'd0};
    tbl[2] = '{4'd15, 4'd15, 9'd225};
    tbl[3] = '{4'd0, 4'd9, 9'd0};
    tbl[4] = '{4'd1, 4'd1, 9'd1};
    mcand = 0;
    mplier = 0;
    repeat (3) begin
      @(negedge clk);
      check("reset outputs", {4'b0, outs}, 9'd0);
    end
    rst_n = 1;
    start = 0;
    repeat (2) begin
      @(negedge clk);
      check("post-reset idle", {4'b0, outs}, 9'd0);
    end
    for (int i = 0; i < 5; i++) run(tbl[i].a, tbl[i].b, 0, tbl[i].prod);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] a, b;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      run(a, b, 0, 9'(a * b));
    end
    run(4'd9, 4'd5, 1, 9'd45);
    repeat (3) begin
      @(negedge clk);
      check("held done", {4'b0, outs}, 9'b0_0000_0001);
    end
    start = 0;
    @(negedge clk);
    check("drop start idle", {4'b0, outs}, 9'd0);
    run(4'd6, 4'd3, 0, 9'd18);
    mcand = 7;
    mplier = 6;
    start = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 0;
    end
    rst_n = 0;
    #1 check("async reset mid-run", {4'b0, outs}, 9'd0);
    @(negedge clk);
    rst_n = 1;
    check("reset held idle", {4'b0, outs}, 9'd0);
    @(negedge clk);
    check("idle after mid-run reset", {4'b0, outs}, 9'd0);
    run(4'd7, 4'd6, 0, 9'd42);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
